// File: rtl/arc_if_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package arc_if_pkg;

  typedef enum logic [2:0] {
    FS_BOOT  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_HOLD  = 3'd3,
    FS_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0180;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcadd4;
  } if_id_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_skid.sv
// Single-entry skid buffer holding a fetched word while the decode stage is stalled.
module if_id_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        rel,
  input  logic        clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pcadd4,
  output logic        valid,
  output logic [31:0] q_instr,
  output logic [31:0] q_pcadd4
);

  logic        vld_p0;
  logic [31:0] instr_p0;
  logic [31:0] pcadd4_p0;

  // occupancy flag: clear beats load beats release
  always_ff @(posedge clk) begin
    if (rst)        vld_p0 <= 1'b0;
    else if (clear) vld_p0 <= 1'b0;
    else if (load)  vld_p0 <= 1'b1;
    else if (rel)   vld_p0 <= 1'b0;
  end

  // payload captured on load only
  always_ff @(posedge clk) begin
    if (load) begin
      instr_p0  <= d_instr;
      pcadd4_p0 <= d_pcadd4;
    end
  end

  assign valid    = vld_p0;
  assign q_instr  = instr_p0;
  assign q_pcadd4 = pcadd4_p0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: PC ownership, next-PC select, imem handshake, IF/ID register.
module if_fetch_ctrl
  import arc_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr_pcadd4,
  output logic [31:0] o_addr_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_exc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_addr_branch,
  input  logic        i_jump,
  input  logic [31:0] i_addr_jump,
  output logic        o_imem_req,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pcadd4,
  output logic        o_addr_misalign
);

  fetch_state_e state_p0, state_d;
  logic [31:0]  pc_p0, pc_d;
  logic         kill_p0, kill_d;
  logic         req_p0;
  logic         misalign_p0;
  if_id_t       id_p1;

  logic         redir_act;
  logic [31:0]  redir_tgt;
  logic         outstanding;
  logic         rsp_live;
  logic         skid_load;
  logic         skid_rel;
  logic         id_load_wait;
  logic         skid_vld;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pcadd4;

  assign redir_act = (state_p0 != FS_BOOT) && (i_exc || i_branch_taken || i_jump);
  assign redir_tgt = i_exc ? EXC_VEC : (i_branch_taken ? i_addr_branch : i_addr_jump);

  // a response is still owed after this edge: fresh grant, or an unanswered one in flight
  assign outstanding = (state_p0 == FS_REQ && i_imem_gnt) ||
                       (((state_p0 == FS_WAIT) || kill_p0) && !i_imem_rvalid);

  assign rsp_live     = (state_p0 == FS_WAIT) && i_imem_rvalid && !kill_p0;
  assign id_load_wait = rsp_live && !i_stall && !redir_act;
  assign skid_load    = rsp_live &&  i_stall && !redir_act;
  assign skid_rel     = (state_p0 == FS_HOLD) && !i_stall && !redir_act;

  if_id_skid u_skid (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (skid_load),
    .rel      (skid_rel),
    .clear    (redir_act),
    .d_instr  (i_imem_rdata),
    .d_pcadd4 (i_addr_pcadd4),
    .valid    (skid_vld),
    .q_instr  (skid_instr),
    .q_pcadd4 (skid_pcadd4)
  );

  // next-state, next-PC and kill selection; redirect overrides stall and normal sequencing
  always_comb begin
    state_d = state_p0;
    pc_d    = pc_p0;
    kill_d  = kill_p0;
    if (kill_p0 && i_imem_rvalid) kill_d = 1'b0;
    if (redir_act) begin
      pc_d   = redir_tgt;
      kill_d = outstanding;
      if (is_misaligned(redir_tgt)) state_d = FS_FAULT;
      else if (outstanding)         state_d = FS_WAIT;
      else                          state_d = FS_REQ;
    end else begin
      case (state_p0)
        FS_BOOT: state_d = FS_REQ;
        FS_REQ:  if (i_imem_gnt) state_d = FS_WAIT;
        FS_WAIT: begin
          if (i_imem_rvalid) begin
            if (kill_p0) begin
              state_d = FS_REQ;
            end else if (!i_stall) begin
              pc_d    = i_addr_pcadd4;
              state_d = FS_REQ;
            end else begin
              state_d = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (!i_stall && skid_vld) begin
            pc_d    = skid_pcadd4;
            state_d = FS_REQ;
          end
        end
        FS_FAULT: state_d = FS_FAULT;
        default:  state_d = FS_BOOT;
      endcase
    end
  end

  // fetch control state with registered req/misalign derived from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_p0    <= FS_BOOT;
      pc_p0       <= RESET_PC;
      kill_p0     <= 1'b0;
      req_p0      <= 1'b0;
      misalign_p0 <= 1'b0;
    end else begin
      state_p0    <= state_d;
      pc_p0       <= pc_d;
      kill_p0     <= kill_d;
      req_p0      <= (state_d == FS_REQ);
      misalign_p0 <= (state_d == FS_FAULT);
    end
  end

  // IF/ID register: flush beats stall beats update; empty cycles drop valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      id_p1 <= '{valid: 1'b0, instr: NOP_INSTR, pcadd4: 32'h0};
    end else if (i_flush) begin
      id_p1.valid <= 1'b0;
      id_p1.instr <= NOP_INSTR;
    end else if (i_stall) begin
      id_p1 <= id_p1;
    end else if (id_load_wait) begin
      id_p1 <= '{valid: 1'b1, instr: i_imem_rdata, pcadd4: i_addr_pcadd4};
    end else if (skid_rel && skid_vld) begin
      id_p1 <= '{valid: 1'b1, instr: skid_instr, pcadd4: skid_pcadd4};
    end else begin
      id_p1.valid <= 1'b0;
    end
  end

  assign o_addr_pc       = pc_p0;
  assign o_imem_req      = req_p0;
  assign o_addr_misalign = misalign_p0;
  assign o_id_valid      = id_p1.valid;
  assign o_id_instr      = id_p1.instr;
  assign o_id_pcadd4     = id_p1.pcadd4;

endmodule
